// File: rtl/ray_march_stepper.sv
`default_nettype none
// ============================================================================
// Module      : ray_march_stepper
// Description : Sphere-tracing ray marcher. For each accepted ray it walks
//               along origin + t*dir. At each step it issues one scene
//               distance query and advances t by the returned distance. It
//               stops on a hit (dist < EPSILON), on the far clip
//               (t > T_MAX), or when the step budget (MAX_STEPS) is spent.
//               All fixed-point values are signed Q8.24.
// Revision    : 1.0 - initial release
// ============================================================================
module ray_march_stepper #(
  parameter int          MAX_STEPS = 64,
  parameter logic [31:0] EPSILON   = 32'h00004000,
  parameter logic [31:0] T_MAX     = 32'h10000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [95:0] ray_origin,
  input  logic [95:0] ray_dir,
  input  logic        obj_sel_in,
  output logic        query_valid,
  output logic [95:0] query_pos,
  output logic        query_obj_sel,
  input  logic [31:0] dist_in,
  input  logic        dist_valid,
  output logic        result_valid,
  input  logic        result_ready,
  output logic        result_hit,
  output logic [31:0] result_t,
  output logic [95:0] result_pos,
  output logic [7:0]  result_steps
);

  localparam logic [7:0] C_MAX_STEPS = 8'(MAX_STEPS);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    POS   = 3'd1,
    ISSUE = 3'd2,
    WAIT  = 3'd3,
    CHECK = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [95:0] r_origin;
  logic [95:0] r_dir;
  logic        r_obj_sel;
  logic [31:0] r_t;
  logic [7:0]  r_steps;
  logic [31:0] r_dist;

  logic [31:0] w_t_next;
  logic        w_hit;
  logic        w_far;
  logic        w_limit;
  logic        w_finish;

  // One component of origin + t*dir: keep bits [55:24] of the 64-bit
  // product (truncate toward -inf) and add with plain 32-bit wrap.
  function automatic logic [31:0] f_march(input logic [31:0] o,
                                          input logic [31:0] d,
                                          input logic [31:0] t);
    logic signed [63:0] p;
    p = $signed({{32{d[31]}}, d}) * $signed({{32{t[31]}}, t});
    return o + 32'(p >>> 24);
  endfunction

  assign w_t_next = r_t + r_dist;
  assign w_hit    = $signed(r_dist) < $signed(EPSILON);
  assign w_far    = $signed(w_t_next) > $signed(T_MAX);
  assign w_limit  = (r_steps == C_MAX_STEPS);
  assign w_finish = w_hit | w_far | w_limit;

  assign query_obj_sel = r_obj_sel;

  // State register; reset aborts any ray in flight immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    w_state_next = r_state;
    start_ready  = 1'b0;
    query_valid  = 1'b0;
    result_valid = 1'b0;
    case (r_state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) w_state_next = POS;
      end
      POS:   w_state_next = ISSUE;
      ISSUE: begin
        query_valid  = 1'b1;
        w_state_next = WAIT;
      end
      WAIT:  if (dist_valid) w_state_next = CHECK;
      CHECK: w_state_next = w_finish ? DONE : POS;
      DONE: begin
        result_valid = 1'b1;
        if (result_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // March datapath: ray latch, query position, step counter and result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_origin     <= '0;
      r_dir        <= '0;
      r_obj_sel    <= 1'b0;
      r_t          <= '0;
      r_steps      <= '0;
      r_dist       <= '0;
      query_pos    <= '0;
      result_hit   <= 1'b0;
      result_t     <= '0;
      result_pos   <= '0;
      result_steps <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_valid) begin
            r_origin  <= ray_origin;
            r_dir     <= ray_dir;
            r_obj_sel <= obj_sel_in;
            r_t       <= '0;
            r_steps   <= '0;
          end
        end
        POS: begin
          query_pos <= {f_march(r_origin[95:64], r_dir[95:64], r_t),
                        f_march(r_origin[63:32], r_dir[63:32], r_t),
                        f_march(r_origin[31:0],  r_dir[31:0],  r_t)};
        end
        ISSUE: r_steps <= r_steps + 8'd1;
        WAIT:  if (dist_valid) r_dist <= dist_in;
        CHECK: begin
          if (w_finish) begin
            // A hit reports the t of the surface point; misses report t_next.
            result_hit   <= w_hit;
            result_t     <= w_hit ? r_t : w_t_next;
            result_pos   <= query_pos;
            result_steps <= r_steps;
          end else begin
            r_t <= w_t_next;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ray_march_stepper.sv
`default_nettype none
// ============================================================================
// Module      : tb_ray_march_stepper
// Description : Self-checking bench for ray_march_stepper. A per-ray loop
//               model predicts every query position and the final result
//               from a table of responder distances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ray_march_stepper;

  localparam int          MAX_STEPS = 64;
  localparam logic [31:0] EPS       = 32'h00004000;
  localparam logic [31:0] TMAX      = 32'h10000000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_valid, start_ready;
  logic [95:0] ray_origin, ray_dir;
  logic        obj_sel_in;
  logic        query_valid, query_obj_sel;
  logic [95:0] query_pos;
  logic [31:0] dist_in;
  logic        dist_valid;
  logic        result_valid, result_ready, result_hit;
  logic [31:0] result_t;
  logic [95:0] result_pos;
  logic [7:0]  result_steps;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] dist_arr [256];
  logic [95:0] exp_pos [$];

  ray_march_stepper #(.MAX_STEPS(MAX_STEPS), .EPSILON(EPS), .T_MAX(TMAX)) dut (
    .clk(clk), .rst(rst),
    .start_valid(start_valid), .start_ready(start_ready),
    .ray_origin(ray_origin), .ray_dir(ray_dir), .obj_sel_in(obj_sel_in),
    .query_valid(query_valid), .query_pos(query_pos), .query_obj_sel(query_obj_sel),
    .dist_in(dist_in), .dist_valid(dist_valid),
    .result_valid(result_valid), .result_ready(result_ready),
    .result_hit(result_hit), .result_t(result_t),
    .result_pos(result_pos), .result_steps(result_steps)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Real-valued intent: o + t*d in Q8.24, floor of the scaled product.
  function automatic logic [31:0] point_on_ray(input logic [31:0] o, input logic [31:0] d,
                                               input logic [31:0] t);
    longint p;
    p = longint'($signed(d)) * longint'($signed(t));
    return o + 32'(p >>> 24);
  endfunction

  // Sphere-tracing reference: walk the ray against dist_arr.
  task automatic model(input logic [95:0] o, input logic [95:0] d,
                       output logic hit, output logic [31:0] rt,
                       output logic [95:0] pos, output logic [7:0] steps);
    logic [31:0] t, tn, dv;
    t = 0; hit = 0; rt = 0; pos = 0; steps = 0;
    exp_pos.delete();
    for (int s = 1; s <= MAX_STEPS; s++) begin
      pos = {point_on_ray(o[95:64], d[95:64], t), point_on_ray(o[63:32], d[63:32], t),
             point_on_ray(o[31:0], d[31:0], t)};
      exp_pos.push_back(pos);
      steps = 8'(s);
      dv = dist_arr[s-1];
      if ($signed(dv) < $signed(EPS)) begin
        hit = 1; rt = t; return;
      end
      tn = t + dv;
      if ($signed(tn) > $signed(TMAX) || s == MAX_STEPS) begin
        rt = tn; return;
      end
      t = tn;
    end
  endtask

  task automatic run_ray(input logic [95:0] o, input logic [95:0] d, input logic sel,
                         input int lat, input int hold);
    logic        e_hit;
    logic [31:0] e_t;
    logic [95:0] e_pos;
    logic [7:0]  e_steps;
    int cyc, qn, pend, last_q;
    bit done, prev_q;
    model(o, d, e_hit, e_t, e_pos, e_steps);
    @(negedge clk);
    start_valid = 1; ray_origin = o; ray_dir = d; obj_sel_in = sel;
    dist_valid = 1; dist_in = 32'h0;   // stray response in IDLE must be ignored
    check_eq("start_ready_idle", start_ready, 1);
    @(negedge clk);
    start_valid = 0; ray_origin = {3{$urandom}}; ray_dir = {3{$urandom}}; obj_sel_in = ~sel;
    cyc = 1; qn = 0; pend = 0; last_q = 0; done = 0; prev_q = 0;
    while (!done && cyc < 2000) begin
      dist_valid = 0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          dist_valid = 1;
          dist_in = dist_arr[qn-1];
        end
      end
      if (query_valid) begin
        if (qn == 0) check_eq("first_query_cycle", cyc, 2);
        else if (lat == 1) check_eq("iteration_cycles", cyc - last_q, 4);
        check_eq("single_outstanding", {prev_q, dist_valid}, 0);
        if (qn < exp_pos.size()) check_eq("query_pos", query_pos, exp_pos[qn]);
        else check_eq("extra_query", qn, exp_pos.size() - 1);
        check_eq("query_obj_sel", query_obj_sel, sel);
        last_q = cyc; qn++; pend = lat;
      end
      prev_q = query_valid;
      if (result_valid) done = 1;
      else begin
        @(negedge clk);
        cyc++;
      end
    end
    dist_valid = 0;
    if (!done) check_eq("result_timeout", 0, 1);
    check_eq("query_count", qn, e_steps);
    check_eq("result_hit", result_hit, e_hit);
    check_eq("result_t", result_t, e_t);
    check_eq("result_pos", result_pos, e_pos);
    check_eq("result_steps", result_steps, e_steps);
    for (int i = 0; i < hold; i++) begin
      dist_valid = 1; dist_in = $urandom;   // ignored outside WAIT
      @(negedge clk);
      check_eq("bp_result_valid", result_valid, 1);
      check_eq("bp_start_ready", start_ready, 0);
      check_eq("bp_stable", {result_hit, result_t, result_steps, result_pos[31:0]},
               {e_hit, e_t, e_steps, e_pos[31:0]});
    end
    dist_valid = 0; result_ready = 1;
    @(negedge clk);
    result_ready = 0;
    check_eq("accept_result_valid", result_valid, 0);
    check_eq("accept_start_ready", start_ready, 1);
    @(negedge clk);
    check_eq("single_accept", {result_valid, query_valid}, 0);
  endtask

  function automatic logic [31:0] rand_dir();
    return 32'($signed($urandom_range(0, 32'h02000000)) - 32'sh01000000);
  endfunction

  initial begin
    logic [95:0] o, d;
    rst = 1; start_valid = 0; ray_origin = 0; ray_dir = 0; obj_sel_in = 0;
    dist_in = 0; dist_valid = 0; result_ready = 0;
    #12;
    check_eq("rst_start_ready", start_ready, 1);
    check_eq("rst_outputs", {query_valid, query_obj_sel, result_valid, result_hit, result_steps},
             0);
    check_eq("rst_vectors", {query_pos, result_pos[31:0]}, 0);
    @(negedge clk); rst = 0;

    // Hit on unit sphere from z=-3, with 5 cycles of back-pressure.
    dist_arr[0] = 32'h02000000; dist_arr[1] = 32'h0;
    run_ray({32'h0, 32'h0, 32'hFD000000}, {32'h0, 32'h0, 32'h01000000}, 1'b0, 1, 5);
    check_eq("hit_case_t", result_t, 32'h02000000);
    check_eq("hit_case_pos", result_pos[31:0], 32'hFF000000);

    // Far-clip miss: constant 2.0.
    for (int i = 0; i < 256; i++) dist_arr[i] = 32'h02000000;
    run_ray({32'h0, 32'h0, 32'hFD000000}, {32'h0, 32'h0, 32'h01000000}, 1'b1, 1, 0);
    check_eq("far_miss_steps", result_steps, 9);

    // Step-limit miss: 64 x 0.25 lands exactly on T_MAX, which is not beyond it.
    for (int i = 0; i < 256; i++) dist_arr[i] = 32'h00400000;
    run_ray({32'h01000000, 32'h0, 32'h0}, {32'h0, 32'h01000000, 32'h0}, 1'b0, 1, 1);
    check_eq("limit_t", result_t, TMAX);

    // Negative first distance is a hit.
    dist_arr[0] = 32'hFF800000;
    run_ray({32'h0, 32'h0, 32'hFD000000}, {32'h0, 32'h0, 32'h01000000}, 1'b0, 2, 0);

    // Exactly EPSILON is not a hit; one below it is.
    dist_arr[0] = EPS; dist_arr[1] = EPS - 1;
    run_ray({32'h0, 32'h0, 32'h0}, {32'h01000000, 32'h0, 32'h0}, 1'b1, 3, 2);

    // Reset while waiting for a distance.
    @(negedge clk);
    start_valid = 1; obj_sel_in = 1;
    ray_origin = {32'h01000000, 32'h02000000, 32'h03000000};
    ray_dir = {32'h0, 32'h0, 32'h01000000};
    @(negedge clk); start_valid = 0;
    for (int i = 0; i < 10 && !query_valid; i++) @(negedge clk);
    check_eq("rst_test_query_seen", query_valid, 1);
    @(negedge clk);
    #1 rst = 1;
    #1;
    check_eq("async_rst_start_ready", start_ready, 1);
    @(negedge clk); rst = 0; dist_valid = 1; dist_in = 32'h0;
    @(negedge clk); dist_valid = 0;
    for (int i = 0; i < 6; i++) begin
      check_eq("post_rst_idle", {start_ready, query_valid, result_valid, query_obj_sel}, 4'b1000);
      check_eq("post_rst_data", {result_hit, result_t, result_steps, query_pos[31:0]}, 0);
      check_eq("post_rst_pos", result_pos, 0);
      @(negedge clk);
    end

    // Randomized rays.
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < 256; i++) begin
        if ($urandom_range(0, 9) == 0)
          dist_arr[i] = 32'($signed($urandom_range(0, 32'h8000)) - 32'sh4000);
        else
          dist_arr[i] = $urandom_range(0, 32'h01800000);
      end
      o = {32'($signed($urandom_range(0, 32'h08000000)) - 32'sh04000000),
           32'($signed($urandom_range(0, 32'h08000000)) - 32'sh04000000),
           32'($signed($urandom_range(0, 32'h08000000)) - 32'sh04000000)};
      d = {rand_dir(), rand_dir(), rand_dir()};
      run_ray(o, d, 1'($urandom_range(0, 1)), $urandom_range(1, 3), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ray_march_stepper.md
RAY_MARCH_STEPPER -- requirements
Module: ray_march_stepper

Interface
REQ-001 Parameter MAX_STEPS, default 64, is the maximum number of scene queries issued per ray (range 1..255).
REQ-002 Parameter EPSILON, default 32'h00004000, is the hit threshold in Q8.24 (about 0.001).
REQ-003 Parameter T_MAX, default 32'h10000000, is the far clip distance in Q8.24 (16.0).
REQ-004 clk  in  1  is the single clock; all state is updated on its rising edge.
REQ-005 rst  in  1  is the reset, asynchronous and active-high.
REQ-006 start_valid  in  1  indicates that a ray request is present.
REQ-007 start_ready  out  1  is high only in IDLE.
REQ-008 ray_origin  in  96  is a vec3 {x,y,z}, each component signed Q8.24.
REQ-009 ray_dir  in  96  is a vec3 in Q8.24, normalised by the producer.
REQ-010 obj_sel_in  in  1  selects the scene object (0 sphere, 1 cube).
REQ-011 query_valid  out  1  is a one-cycle pulse that issues a scene query.
REQ-012 query_pos  out  96  is the query position, registered.
REQ-013 query_obj_sel  out  1  is the latched obj_sel_in.
REQ-014 dist_in  in  32  is the signed Q8.24 distance returned by the scene query.
REQ-015 dist_valid  in  1  qualifies dist_in; there is no back-pressure toward the responder.
REQ-016 result_valid  out  1  indicates that a result is available.
REQ-017 result_ready  in  1  is the consumer acceptance signal.
REQ-018 result_hit  out  1  is 1 on a hit and 0 on a miss.
REQ-019 result_t  out  32  is the final march distance in Q8.24.
REQ-020 result_pos  out  96  is the last queried position.
REQ-021 result_steps  out  8  is the number of queries issued.

Function
REQ-022 The FSM states shall be IDLE, POS, ISSUE, WAIT, CHECK and DONE.
REQ-023 In IDLE, start_valid&&start_ready shall latch ray_origin, ray_dir and obj_sel_in, clear t and steps to 0, and go to POS.
REQ-024 POS shall register query_pos = origin + t*dir per component for one cycle, then go to ISSUE.
REQ-025 Each product shall be formed as a 64-bit signed product, take bits [55:24] (truncation), and add with 32-bit wrap-around and no saturation.
REQ-026 ISSUE shall assert query_valid for exactly one cycle, increment steps, and go to WAIT.
REQ-027 WAIT shall hold until dist_valid, then capture dist_in and go to CHECK; the wait is unbounded with no timeout.
REQ-028 dist_valid shall be ignored in every state other than WAIT.
REQ-029 In CHECK, if dist is less than EPSILON (signed compare, so negative distances count), the result is a hit: t is unchanged and result_pos = query_pos.
REQ-030 Otherwise in CHECK, t_next = t + dist; if t_next is greater than T_MAX (signed compare), the result is a miss with result_t = t_next.
REQ-031 Otherwise in CHECK, if steps == MAX_STEPS, the result is a miss with result_t = t_next.
REQ-032 Otherwise in CHECK, t shall be set to t_next and the FSM shall go to POS.
REQ-033 The hit test shall take priority over the T_MAX test, which shall take priority over the MAX_STEPS test.
REQ-034 On a result, CHECK shall load result_* and go to DONE; result_valid is high in DONE only.
REQ-035 In DONE, result_* shall hold stable until result_valid&&result_ready; then the FSM returns to IDLE, with start_ready high on the next cycle.
REQ-036 Timing shall be: start accepted at edge k; POS in cycle k+1; query_valid in cycle k+2; an iteration is 4 cycles when dist_valid follows query_valid by 1 cycle.
REQ-037 At most one query shall be outstanding at any time.

Reset
REQ-038 When rst is asserted, the FSM shall go to IDLE immediately, regardless of clk.
REQ-039 Under reset, all outputs except start_ready shall be 0, start_ready shall be 1, and the internal t, steps and latched ray shall be 0.
REQ-040 Reset mid-operation shall abort the ray with no result, and a dist_valid arriving after reset shall be ignored.

Verification
REQ-041 Hit case: origin (0,0,-3.0), dir (0,0,1.0), sphere model r=1 with latency 1 -> one query at z=-3 returning 2.0, then one at z=-1 returning 0 -> hit=1, t=32'h02000000, steps=2, pos z=32'hFF000000.
REQ-042 Far-clip miss: responder always returns 2.0 -> hit=0, steps=9, t=32'h12000000.
REQ-043 Step-limit miss: MAX_STEPS=4, responder always returns 0.5 -> hit=0, steps=4, t=32'h02000000.
REQ-044 Negative distance: first dist_in=32'hFF800000 (-0.5) -> hit=1, t=0, steps=1.
REQ-045 Back-pressure: result_ready held low for 5 cycles -> result_valid stays high, result_* is stable, start_ready stays 0, and there is exactly one accept.
REQ-046 Reset mid-WAIT: rst pulsed while in WAIT, then dist_valid arrives -> start_ready=1, all outputs 0, no result_valid and no query_valid.
